bpu_set_assoc: RTL and testbench

Parametrised set-associative branch target buffer with per-entry saturating direction counters, the successor to the direct-mapped single-way predictor. Sits beside the IF stage: combinationally predicts direction and target for `pc_if`, and is trained by the EX stage once each branch or jump resolves. Adds configurable ways, set count and counter width, round-robin replacement, allocate-on-taken and a synchronous flush.

---
 rtl/bpu_pkg.sv | 31 +++
 rtl/bpu_way.sv | 80 ++++++++
 rtl/bpu_set_assoc.sv | 159 +++++++++++++++
 tb/tb_bpu_set_assoc.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared constants and counter helpers for the set-associative branch predictor.
// Optional gshare indexing is selected with the BPU_GSHARE_EN macro.
package bpu_pkg;

  localparam int BPU_ADDR_W  = 32;
  localparam int BPU_INDEX_W = 6;
  localparam int BPU_WAYS    = 2;
  localparam int BPU_CNT_W   = 2;
  localparam int CNT_MAX_W   = 8;

  localparam logic PRED_TAKEN     = 1'b1;
  localparam logic PRED_NOT_TAKEN = 1'b0;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  // Weakly taken: only the MSB of a w-bit counter set.
  function automatic cnt_t cnt_init(input int w);
    return cnt_t'(1) << (w - 1);
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c, input int w);
    cnt_t max_v;
    max_v = (cnt_t'(1) << w) - cnt_t'(1);
    return (c == max_v) ? c : c + cnt_t'(1);
  endfunction

  function automatic cnt_t sat_dec(input cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/bpu_way.sv
// One way of the branch target buffer: valid/tag/target (and counter unless
// BPU_GSHARE_EN is defined) per set, with lookup and update-side comparators.
module bpu_way
  import bpu_pkg::*;
#(
  parameter int ADDR_W  = BPU_ADDR_W,
  parameter int INDEX_W = BPU_INDEX_W,
  parameter int CNT_W   = BPU_CNT_W,
  localparam int TAG_W  = ADDR_W - INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_go,
  input  logic [INDEX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic [ADDR_W-1:0]  lk_target,
`ifndef BPU_GSHARE_EN
  output logic               lk_taken,
`endif
  input  logic [INDEX_W-1:0] up_idx,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               up_hit,
  output logic               up_valid,
  input  logic               up_train,
  input  logic               up_alloc,
  input  logic               up_taken,
  input  logic [ADDR_W-1:0]  up_target
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags    [SETS];
  logic [ADDR_W-1:0] targets [SETS];

  assign lk_hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lk_target = targets[lk_idx];
  assign up_valid  = valid[up_idx];
  assign up_hit    = up_valid && (tags[up_idx] == up_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush_go) begin
      valid <= '0;
    end else if (up_alloc) begin
      valid[up_idx] <= 1'b1;
    end
  end

`ifndef BPU_GSHARE_EN
  logic [CNT_W-1:0] cnts [SETS];
  logic [CNT_W-1:0] cnt_trained;

  assign lk_taken    = cnts[lk_idx][CNT_W-1];
  assign cnt_trained = (up_taken == PRED_TAKEN) ?
                       CNT_W'(sat_inc(cnt_t'(cnts[up_idx]), CNT_W)) :
                       CNT_W'(sat_dec(cnt_t'(cnts[up_idx])));
`endif

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (up_alloc) begin
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= up_target;
`ifndef BPU_GSHARE_EN
      cnts[up_idx]    <= CNT_W'(cnt_init(CNT_W));
`endif
    end else if (up_train) begin
      if (up_taken == PRED_TAKEN) begin
        targets[up_idx] <= up_target;
      end
`ifndef BPU_GSHARE_EN
      cnts[up_idx] <= cnt_trained;
`endif
    end
  end

endmodule

// File: rtl/bpu_set_assoc.sv
// Set-associative branch target buffer with round-robin replacement and flush.
// Defining BPU_GSHARE_EN moves direction counters to a GHR-xor-indexed table.
module bpu_set_assoc
  import bpu_pkg::*;
#(
  parameter int ADDR_W  = BPU_ADDR_W,
  parameter int INDEX_W = BPU_INDEX_W,
  parameter int WAYS    = BPU_WAYS,
  parameter int CNT_W   = BPU_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pre_jmp_status,
  output logic [ADDR_W-1:0] pre_jmp_target,
  output logic              pre_hit,
  input  logic [ADDR_W-1:0] pc_ex,
  input  logic              opt_is_jmp,
  input  logic [ADDR_W-1:0] ifjmp_target,
  input  logic              jmp_res,
  input  logic              flush
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [INDEX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               flush_go, upd_go, alloc_en, any_up_hit;
  logic [WAYS-1:0]    way_hit, way_up_hit, way_up_valid;
  logic [ADDR_W-1:0]  way_target [WAYS];
  logic               hit, hit_taken, found_invalid;
  logic [ADDR_W-1:0]  hit_target;
  logic [PTR_W-1:0]   ptr_cur, victim;
  logic               unused_pc_lsbs;

  assign lk_idx = pc_if[INDEX_W+1:2];
  assign lk_tag = pc_if[ADDR_W-1:INDEX_W+2];
  assign up_idx = pc_ex[INDEX_W+1:2];
  assign up_tag = pc_ex[ADDR_W-1:INDEX_W+2];
  assign unused_pc_lsbs = ^{pc_if[1:0], pc_ex[1:0]};

  // A flush in the same cycle as an update drops the update.
  assign flush_go   = rdy & flush;
  assign upd_go     = rdy & opt_is_jmp & ~flush;
  assign any_up_hit = |way_up_hit;
  assign alloc_en   = upd_go & (jmp_res == PRED_TAKEN) & ~any_up_hit;

`ifndef BPU_GSHARE_EN
  logic [WAYS-1:0] way_taken;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    bpu_way #(
      .ADDR_W  (ADDR_W),
      .INDEX_W (INDEX_W),
      .CNT_W   (CNT_W)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_go  (flush_go),
      .lk_idx    (lk_idx),
      .lk_tag    (lk_tag),
      .lk_hit    (way_hit[w]),
      .lk_target (way_target[w]),
`ifndef BPU_GSHARE_EN
      .lk_taken  (way_taken[w]),
`endif
      .up_idx    (up_idx),
      .up_tag    (up_tag),
      .up_hit    (way_up_hit[w]),
      .up_valid  (way_up_valid[w]),
      .up_train  (upd_go & way_up_hit[w]),
      .up_alloc  (alloc_en & (victim == PTR_W'(w))),
      .up_taken  (jmp_res),
      .up_target (ifjmp_target)
    );
  end

  always_comb begin
    hit        = 1'b0;
    hit_target = '0;
`ifndef BPU_GSHARE_EN
    hit_taken  = PRED_NOT_TAKEN;
`endif
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit        = 1'b1;
        hit_target = way_target[w];
`ifndef BPU_GSHARE_EN
        hit_taken  = way_taken[w];
`endif
      end
    end
  end

  // An invalid way is always filled before the round-robin pointer is consulted.
  always_comb begin
    victim        = ptr_cur;
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !way_up_valid[w]) begin
        victim        = PTR_W'(w);
        found_invalid = 1'b1;
      end
    end
  end

  if (WAYS > 1) begin : g_ptr
    logic [PTR_W-1:0] ptr [SETS];

    assign ptr_cur = ptr[up_idx];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SETS; i++) ptr[i] <= '0;
      end else if (flush_go) begin
        for (int i = 0; i < SETS; i++) ptr[i] <= '0;
      end else if (alloc_en && !found_invalid) begin
        ptr[up_idx] <= ptr[up_idx] + 1'b1;
      end
    end
  end else begin : g_no_ptr
    assign ptr_cur = '0;
  end

`ifdef BPU_GSHARE_EN
  logic [INDEX_W-1:0] ghr;
  logic [CNT_W-1:0]   cnt_tab [SETS];
  logic [INDEX_W-1:0] up_cidx;
  logic [CNT_W-1:0]   cnt_trained;

  assign hit_taken   = cnt_tab[lk_idx ^ ghr][CNT_W-1];
  assign up_cidx     = up_idx ^ ghr;
  assign cnt_trained = (jmp_res == PRED_TAKEN) ?
                       CNT_W'(sat_inc(cnt_t'(cnt_tab[up_cidx]), CNT_W)) :
                       CNT_W'(sat_dec(cnt_t'(cnt_tab[up_cidx])));

  // Counter indexing and training both use the history before this shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
      for (int i = 0; i < SETS; i++) cnt_tab[i] <= CNT_W'(cnt_init(CNT_W));
    end else if (upd_go) begin
      ghr <= INDEX_W'({ghr, jmp_res});
      if (any_up_hit) begin
        cnt_tab[up_cidx] <= cnt_trained;
      end
    end
  end
`endif

  assign pre_hit        = rst_n & hit;
  assign pre_jmp_status = rst_n & hit & hit_taken;
  assign pre_jmp_target = pre_jmp_status ? hit_target : '0;

endmodule

// File: tb/tb_bpu_set_assoc.sv
// Directed self-checking bench for bpu_set_assoc (WAYS=2, INDEX_W=6, CNT_W=2);
// the history-indexed section is selected by BPU_GSHARE_EN.
module tb_bpu_set_assoc;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [31:0] pc_if;
  logic        pre_jmp_status;
  logic [31:0] pre_jmp_target;
  logic        pre_hit;
  logic [31:0] pc_ex;
  logic        opt_is_jmp;
  logic [31:0] ifjmp_target;
  logic        jmp_res;
  logic        flush;

  int checks_total  = 0;
  int checks_passed = 0;

  bpu_set_assoc #(
    .ADDR_W  (32),
    .INDEX_W (6),
    .WAYS    (2),
    .CNT_W   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .pc_if          (pc_if),
    .pre_jmp_status (pre_jmp_status),
    .pre_jmp_target (pre_jmp_target),
    .pre_hit        (pre_hit),
    .pc_ex          (pc_ex),
    .opt_is_jmp     (opt_is_jmp),
    .ifjmp_target   (ifjmp_target),
    .jmp_res        (jmp_res),
    .flush          (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of update/flush activity, then returns the bus to idle.
  task automatic applyStimulus(input logic upd, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic taken,
                               input logic do_flush, input logic en);
    @(negedge clk);
    opt_is_jmp   = upd;
    pc_ex        = pc;
    ifjmp_target = tgt;
    jmp_res      = taken;
    flush        = do_flush;
    rdy          = en;
    @(posedge clk);
    #1;
    opt_is_jmp = 1'b0;
    flush      = 1'b0;
    rdy        = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] pc,
                             input logic exp_hit, input logic exp_status,
                             input logic [31:0] exp_target);
    @(negedge clk);
    pc_if = pc;
    #1;
    checks_total++;
    assert ({pre_hit, pre_jmp_status, pre_jmp_target} === {exp_hit, exp_status, exp_target})
      checks_passed++;
    else
      $error("[TB] FAIL %s: observed hit=%0b status=%0b target=%h, expected hit=%0b status=%0b target=%h",
             tag, pre_hit, pre_jmp_status, pre_jmp_target, exp_hit, exp_status, exp_target);
  endtask

  initial begin
    rst_n        = 1'b0;
    rdy          = 1'b1;
    pc_if        = '0;
    pc_ex        = '0;
    opt_is_jmp   = 1'b0;
    ifjmp_target = '0;
    jmp_res      = 1'b0;
    flush        = 1'b0;

    checkOutput("in_reset", 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("cold_lookup", 32'h100, 1'b0, 1'b0, 32'h0);

`ifndef BPU_GSHARE_EN
    applyStimulus(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    checkOutput("alloc_taken", 32'h100, 1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 32'h104, 32'h500, 1'b0, 1'b0, 1'b1);
    checkOutput("miss_not_taken_no_alloc", 32'h104, 1'b0, 1'b0, 32'h0);

    // Counter 10 -> 01 -> 10 -> 11 (saturates) -> 10 -> 01.
    applyStimulus(1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    checkOutput("hyst_nt_once", 32'h100, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    checkOutput("hyst_t_once", 32'h100, 1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 32'h100, 32'h210, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h100, 32'h220, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h100, 32'h240, 1'b1, 1'b0, 1'b1);
    checkOutput("hyst_sat_target_upd", 32'h100, 1'b1, 1'b1, 32'h240);
    applyStimulus(1'b1, 32'h100, 32'h999, 1'b0, 1'b0, 1'b1);
    checkOutput("hyst_nt_first", 32'h100, 1'b1, 1'b1, 32'h240);
    applyStimulus(1'b1, 32'h100, 32'h999, 1'b0, 1'b0, 1'b1);
    checkOutput("hyst_nt_second", 32'h100, 1'b1, 1'b0, 32'h0);

    // 0x100, 0x200, 0x300 and 0x400 all map to set 0.
    applyStimulus(1'b1, 32'h200, 32'hA00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h300, 32'hB00, 1'b1, 1'b0, 1'b1);
    checkOutput("repl_evicted_100", 32'h100, 1'b0, 1'b0, 32'h0);
    checkOutput("repl_kept_200", 32'h200, 1'b1, 1'b1, 32'hA00);
    checkOutput("repl_kept_300", 32'h300, 1'b1, 1'b1, 32'hB00);
    applyStimulus(1'b1, 32'h400, 32'hC00, 1'b1, 1'b0, 1'b1);
    checkOutput("repl_rr_400", 32'h400, 1'b1, 1'b1, 32'hC00);
    checkOutput("repl_rr_evicted_200", 32'h200, 1'b0, 1'b0, 32'h0);
    checkOutput("repl_rr_kept_300", 32'h300, 1'b1, 1'b1, 32'hB00);

    applyStimulus(1'b1, 32'h104, 32'h700, 1'b1, 1'b0, 1'b0);
    checkOutput("rdy_low_no_alloc", 32'h104, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rdy_low_no_flush", 32'h300, 1'b1, 1'b1, 32'hB00);

    applyStimulus(1'b1, 32'h400, 32'hD00, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_wins_400", 32'h400, 1'b0, 1'b0, 32'h0);
    checkOutput("flush_clears_300", 32'h300, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h100, 32'h600, 1'b1, 1'b0, 1'b1);
    checkOutput("post_flush_alloc", 32'h100, 1'b1, 1'b1, 32'h600);
`else
    // GHR 0 -> 1 on the allocating update; NT trains table[0^1] and GHR -> 2.
    applyStimulus(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    checkOutput("gshare_hist2_taken", 32'h100, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h104, 32'h700, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 32'h104, 32'h700, 1'b1, 1'b0, 1'b1);
    checkOutput("gshare_hist1_not_taken", 32'h100, 1'b1, 1'b0, 32'h0);
    checkOutput("gshare_alloc_104", 32'h104, 1'b1, 1'b1, 32'h700);
`endif

    checkOutput("pre_reset_hit", 32'h100, 1'b1, pre_jmp_status, pre_jmp_target);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    checkOutput("mid_reset_outputs_zero", 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("post_reset_miss", 32'h100, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
